// File: rtl/tsf_access_seq.sv
// Access sequencer for tri-state decoders on a shared S1/S2 bus: setup, access, turnaround.
// Optional eight-code sweep is built when TSF_SEQ_SWEEP_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start, all nCS high
// SETUP  | code driven, all nCS high
// ACCESS | nCS[dev] low, bus sampled on final edge
// TURN   | all nCS high, bus turnaround before done
module tsf_access_seq #(
  parameter int NDEV      = 2,
  parameter int SETUP_CYC = 1,
  parameter int ACC_CYC   = 2,
  parameter int TURN_CYC  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef TSF_SEQ_SWEEP_EN
  input  logic            sweep,
  output logic [15:0]     sweep_res,
`endif
  input  logic [2:0]      code,
  input  logic [2:0]      dev,
  input  logic            S1,
  input  logic            S2,
  output logic            Ec,
  output logic            Eb,
  output logic            Ea,
  output logic [NDEV-1:0] nCS,
  output logic            busy,
  output logic            done,
  output logic [1:0]      result,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, TURN} stateT;

  localparam logic [7:0]      SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0]      ACC_LD   = 8'(ACC_CYC - 1);
  localparam logic [7:0]      TURN_LD  = (TURN_CYC > 0) ? 8'(TURN_CYC - 1) : 8'd0;
  localparam logic [3:0]      NDEV_W   = 4'(NDEV);
  localparam logic [NDEV-1:0] SEL_ONE  = NDEV'(1);

  stateT      state;
  logic [7:0] phaseCnt;
  logic [2:0] devReg;
  logic       phaseEnd;
  logic       txnEnd;
`ifdef TSF_SEQ_SWEEP_EN
  logic       sweepMode;
  logic [2:0] sweepIdx;
`endif

  assign phaseEnd = (phaseCnt == 8'd0);
  // A transaction ends either at the end of TURN or, with no turnaround, at the end of ACCESS.
  assign txnEnd = phaseEnd && ((state == TURN) || ((state == ACCESS) && (TURN_CYC == 0)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      phaseCnt     <= 8'd0;
      devReg       <= 3'd0;
      {Ec, Eb, Ea} <= 3'b000;
      nCS          <= '1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      result       <= 2'b00;
`ifdef TSF_SEQ_SWEEP_EN
      sweepMode    <= 1'b0;
      sweepIdx     <= 3'd0;
      sweep_res    <= 16'h0000;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ({1'b0, dev} < NDEV_W) begin
`ifdef TSF_SEQ_SWEEP_EN
              {Ec, Eb, Ea} <= sweep ? 3'b000 : code;
              sweepMode    <= sweep;
              sweepIdx     <= 3'd0;
`else
              {Ec, Eb, Ea} <= code;
`endif
              devReg   <= dev;
              busy     <= 1'b1;
              state    <= SETUP;
              phaseCnt <= SETUP_LD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (phaseEnd) begin
            nCS      <= ~(SEL_ONE << devReg);
            state    <= ACCESS;
            phaseCnt <= ACC_LD;
          end else begin
            phaseCnt <= phaseCnt - 8'd1;
          end
        end
        ACCESS: begin
          if (phaseEnd) begin
            result   <= {S1, S2};
            nCS      <= '1;
            state    <= TURN;
            phaseCnt <= TURN_LD;
`ifdef TSF_SEQ_SWEEP_EN
            if (sweepMode) sweep_res[{sweepIdx, 1'b0} +: 2] <= {S1, S2};
`endif
          end else begin
            phaseCnt <= phaseCnt - 8'd1;
          end
        end
        TURN: begin
          if (!phaseEnd) phaseCnt <= phaseCnt - 8'd1;
        end
        default: state <= IDLE;
      endcase

      // Later assignments here override the per-state next-state choice.
      if (txnEnd) begin
`ifdef TSF_SEQ_SWEEP_EN
        if (sweepMode && (sweepIdx != 3'd7)) begin
          sweepIdx     <= sweepIdx + 3'd1;
          {Ec, Eb, Ea} <= sweepIdx + 3'd1;
          state        <= SETUP;
          phaseCnt     <= SETUP_LD;
        end else
`endif
        begin
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
          phaseCnt <= 8'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tsf_access_seq.sv
// Directed bench for tsf_access_seq: default-timing instance plus a SETUP=3/ACC=1/TURN=0 instance.
module tb_tsf_access_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, startB;
  logic [2:0] code, dev, codeB, devB;
  logic       S1a, S2a, S1b, S2b;
  logic       EcA, EbA, EaA, busyA, doneA, errA;
  logic       EcB, EbB, EaB, busyB, doneB, errB;
  logic [1:0] nCSA, resultA, nCSB, resultB;
`ifdef TSF_SEQ_SWEEP_EN
  logic        sweepA, sweepB;
  logic [15:0] sweepResA, sweepResB;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference decoder: bus value returned for each code while selected.
  function automatic logic [1:0] decode(input logic [2:0] c);
    case (c)
      3'd0: decode = 2'b01;
      3'd1: decode = 2'b00;
      3'd2: decode = 2'b00;
      3'd3: decode = 2'b11;
      3'd4: decode = 2'b10;
      3'd5: decode = 2'b01;
      3'd6: decode = 2'b00;
      default: decode = 2'b01;
    endcase
  endfunction

  assign {S1a, S2a} = (nCSA != 2'b11) ? decode({EcA, EbA, EaA}) : 2'b00;
  assign {S1b, S2b} = (nCSB != 2'b11) ? decode({EcB, EbB, EaB}) : 2'b00;

  tsf_access_seq dutA (
    .clk(clk), .reset(rst), .start(start),
`ifdef TSF_SEQ_SWEEP_EN
    .sweep(sweepA), .sweep_res(sweepResA),
`endif
    .code(code), .dev(dev), .S1(S1a), .S2(S2a),
    .Ec(EcA), .Eb(EbA), .Ea(EaA), .nCS(nCSA),
    .busy(busyA), .done(doneA), .result(resultA), .err(errA)
  );

  tsf_access_seq #(.NDEV(2), .SETUP_CYC(3), .ACC_CYC(1), .TURN_CYC(0)) dutB (
    .clk(clk), .reset(rst), .start(startB),
`ifdef TSF_SEQ_SWEEP_EN
    .sweep(sweepB), .sweep_res(sweepResB),
`endif
    .code(codeB), .dev(devB), .S1(S1b), .S2(S2b),
    .Ec(EcB), .Eb(EbB), .Ea(EaB), .nCS(nCSB),
    .busy(busyB), .done(doneB), .result(resultB), .err(errB)
  );

  // Bus monitors: low-cycle counts, window starts, overlap and code stability.
  int   lowA0 = 0, lowA1 = 0, winA = 0, fallA = 0, doneCntA = 0;
  int   lowB0 = 0, lowB1 = 0, winB = 0, fallB = 0;
  logic prevLowA = 1'b0, prevLowB = 1'b0, badA = 1'b0, badB = 1'b0;
  logic [2:0] lowCodeA = 3'd0, lowCodeB = 3'd0;

  always @(negedge clk) begin
    if (!nCSA[0]) lowA0 <= lowA0 + 1;
    if (!nCSA[1]) lowA1 <= lowA1 + 1;
    if (nCSA != 2'b11) begin
      if (!prevLowA) begin
        winA     <= winA + 1;
        fallA    <= cyc;
        lowCodeA <= {EcA, EbA, EaA};
      end else if (lowCodeA != {EcA, EbA, EaA}) begin
        badA <= 1'b1;
      end
    end
    if (nCSA == 2'b00) badA <= 1'b1;
    prevLowA <= (nCSA != 2'b11);
    if (doneA) doneCntA <= doneCntA + 1;
  end

  always @(negedge clk) begin
    if (!nCSB[0]) lowB0 <= lowB0 + 1;
    if (!nCSB[1]) lowB1 <= lowB1 + 1;
    if (nCSB != 2'b11) begin
      if (!prevLowB) begin
        winB     <= winB + 1;
        fallB    <= cyc;
        lowCodeB <= {EcB, EbB, EaB};
      end else if (lowCodeB != {EcB, EbB, EaB}) begin
        badB <= 1'b1;
      end
    end
    if (nCSB == 2'b00) badB <= 1'b1;
    prevLowB <= (nCSB != 2'b11);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic waitDone(input bit useB, input int limit, output int atCyc, output logic got);
    got = 1'b0;
    atCyc = -1;
    for (int t = 0; t < limit && !got; t++) begin
      @(negedge clk);
      if (useB ? doneB : doneA) begin
        got = 1'b1;
        atCyc = cyc;
      end
    end
    check("done seen", int'(got), 1);
  endtask

  typedef struct {
    logic [2:0] dev;
    logic [2:0] code;
    logic [1:0] res;
    logic       isErr;
  } vecT;

  vecT        vecs[8];
  logic [2:0] lastCodeA = 3'd0;

  task automatic runA(input int idx, input vecT v);
    int   k, d, b0, b1, bw;
    logic got;
    @(negedge clk);
    b0 = lowA0; b1 = lowA1; bw = winA;
    start = 1'b1; dev = v.dev; code = v.code;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    if (v.isErr) begin
      check($sformatf("v%0d err pulse", idx), int'(errA), 1);
      check($sformatf("v%0d err busy", idx), int'(busyA), 0);
      check($sformatf("v%0d err nCS", idx), int'(nCSA), 3);
      check($sformatf("v%0d err code held", idx), int'({EcA, EbA, EaA}), int'(lastCodeA));
      @(negedge clk);
      check($sformatf("v%0d err width", idx), int'(errA), 0);
      check($sformatf("v%0d err nCS later", idx), int'(nCSA), 3);
    end else begin
      check($sformatf("v%0d code latched", idx), int'({EcA, EbA, EaA}), int'(v.code));
      check($sformatf("v%0d busy", idx), int'(busyA), 1);
      waitDone(1'b0, 20, d, got);
      check($sformatf("v%0d done latency", idx), d - k, 4);
      check($sformatf("v%0d busy at done", idx), int'(busyA), 0);
      check($sformatf("v%0d result", idx), int'(resultA), int'(v.res));
      @(negedge clk);
      check($sformatf("v%0d done width", idx), int'(doneA), 0);
      check($sformatf("v%0d nCS0 low cycles", idx), lowA0 - b0, (v.dev == 3'd0) ? 2 : 0);
      check($sformatf("v%0d nCS1 low cycles", idx), lowA1 - b1, (v.dev == 3'd1) ? 2 : 0);
      check($sformatf("v%0d windows", idx), winA - bw, 1);
      check($sformatf("v%0d select offset", idx), fallA - k, 1);
      lastCodeA = v.code;
    end
  endtask

  initial begin
    int   k, k2, d, d2, b0, b1, bw, dBase;
    logic got;

    rst = 1'b1;
    start = 1'b0; dev = 3'd0; code = 3'd0;
    startB = 1'b0; devB = 3'd0; codeB = 3'd0;
`ifdef TSF_SEQ_SWEEP_EN
    sweepA = 1'b0; sweepB = 1'b0;
`endif
    vecs[0] = '{3'd2, 3'd5, 2'b00, 1'b1};
    vecs[1] = '{3'd0, 3'd3, 2'b11, 1'b0};
    vecs[2] = '{3'd1, 3'd4, 2'b10, 1'b0};
    vecs[3] = '{3'd0, 3'd0, 2'b01, 1'b0};
    vecs[4] = '{3'd7, 3'd2, 2'b00, 1'b1};
    vecs[5] = '{3'd1, 3'd5, 2'b01, 1'b0};
    vecs[6] = '{3'd1, 3'd6, 2'b00, 1'b0};
    vecs[7] = '{3'd0, 3'd7, 2'b01, 1'b0};

    @(negedge clk);
    check("reset nCS", int'(nCSA), 3);
    check("reset code", int'({EcA, EbA, EaA}), 0);
    check("reset busy", int'(busyA), 0);
    check("reset done", int'(doneA), 0);
    check("reset err", int'(errA), 0);
    check("reset result", int'(resultA), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) runA(i, vecs[i]);

    // Back-to-back: second start presented in the done cycle of the first.
    @(negedge clk);
    start = 1'b1; dev = 3'd0; code = 3'b011;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    waitDone(1'b0, 20, d, got);
    check("b2b first latency", d - k, 4);
    check("b2b first result", int'(resultA), 3);
    b1 = lowA1; bw = winA;
    start = 1'b1; dev = 3'd1; code = 3'b100;
    @(negedge clk);
    start = 1'b0;
    k2 = cyc;
    check("b2b no gap", k2 - d, 1);
    check("b2b second busy", int'(busyA), 1);
    check("b2b second code", int'({EcA, EbA, EaA}), 4);
    waitDone(1'b0, 20, d2, got);
    check("b2b second latency", d2 - k2, 4);
    check("b2b second result", int'(resultA), 2);
    check("b2b nCS1 low cycles", lowA1 - b1, 2);
    check("b2b windows", winA - bw, 1);
    check("b2b overlap or code change", int'(badA), 0);

    // Reset in the middle of ACCESS.
    @(negedge clk);
    start = 1'b1; dev = 3'd0; code = 3'b011;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset nCS0 low", int'(nCSA), 2);
    #2 rst = 1'b1;
    #1;
    check("async reset nCS", int'(nCSA), 3);
    check("async reset busy", int'(busyA), 0);
    check("async reset result", int'(resultA), 0);
    check("async reset code", int'({EcA, EbA, EaA}), 0);
    dBase = doneCntA;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("no done after reset", doneCntA - dBase, 0);
    check("idle after reset", int'(busyA), 0);

    // Short-setup instance with no turnaround; a start while busy must be ignored.
    @(negedge clk);
    b0 = lowB0; b1 = lowB1; bw = winB;
    startB = 1'b1; devB = 3'd0; codeB = 3'b011;
    @(negedge clk);
    startB = 1'b0;
    k = cyc;
    check("B busy", int'(busyB), 1);
    @(negedge clk);
    startB = 1'b1; devB = 3'd1; codeB = 3'b101;
    @(negedge clk);
    startB = 1'b0;
    check("B busy start no err", int'(errB), 0);
    check("B code held while busy", int'({EcB, EbB, EaB}), 3);
    waitDone(1'b1, 20, d, got);
    check("B done latency", d - k, 4);
    check("B result", int'(resultB), 3);
    check("B busy at done", int'(busyB), 0);
    repeat (3) @(negedge clk);
    check("B nCS0 low cycles", lowB0 - b0, 1);
    check("B nCS1 never low", lowB1 - b1, 0);
    check("B windows", winB - bw, 1);
    check("B select cycle", fallB - k, 3);
    check("B stays idle", int'(busyB), 0);

`ifdef TSF_SEQ_SWEEP_EN
    @(negedge clk);
    bw = winA;
    sweepA = 1'b1; start = 1'b1; dev = 3'd0; code = 3'b110;
    @(negedge clk);
    start = 1'b0; sweepA = 1'b0;
    k = cyc;
    check("sweep busy", int'(busyA), 1);
    check("sweep first code", int'({EcA, EbA, EaA}), 0);
    waitDone(1'b0, 45, d, got);
    check("sweep done latency", d - k, 32);
    check("sweep_res", int'(sweepResA), 32'h46C1);
    check("sweep result", int'(resultA), 1);
    check("sweep windows", winA - bw, 8);
`endif

    check("A overlap or code change", int'(badA), 0);
    check("B overlap or code change", int'(badB), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
